// File: rtl/generador_seleccion_pkg.sv
// Shared settings for the select generator and the other lab blocks:
// FSM state encoding, default debounce/period values and a counter-width helper.
package generador_seleccion_pkg;

  localparam logic [0:0] MANUAL = 1'b0;
  localparam logic [0:0] AUTO   = 1'b1;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned AUTO_PERIOD_DEF     = 50_000_000;

  // Width of a counter that must reach n-1, never narrower than one bit.
  function automatic int unsigned ancho_contador(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/generador_seleccion_if.sv
// Button/switch inputs and select outputs of the select generator, bundled
// so the driving side and the generator share one port list.
interface generador_seleccion_if;

  logic boton;
  logic modo_auto;
  logic habilitar;
  logic seleccion;
  logic cambio;
  logic boton_limpio;

  modport master (
    output boton, modo_auto, habilitar,
    input  seleccion, cambio, boton_limpio
  );

  modport slave (
    input  boton, modo_auto, habilitar,
    output seleccion, cambio, boton_limpio
  );

endinterface

// File: rtl/generador_seleccion_antirrebote.sv
// Reusable pushbutton conditioner: 2-flop synchronizer followed by a counter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive stable cycles.
module antirrebote
  import generador_seleccion_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic salida
);

  localparam int unsigned    CW      = ancho_contador(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_salida;
  logic [CW-1:0] r_cnt;

  // NOTE: non-blocking assignments so every flop in this block samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_salida <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= entrada;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_salida) begin
        if (r_cnt == CNT_MAX) begin
          r_salida <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign salida = r_salida;

endmodule

// File: rtl/generador_seleccion.sv
// Drives the 2:1 mux select: toggles on clean presses in MANUAL mode and
// alternates every AUTO_PERIOD enabled cycles in AUTO mode.
module generador_seleccion
  import generador_seleccion_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  generador_seleccion_if.slave  bus
);

  localparam int unsigned   PW      = ancho_contador(AUTO_PERIOD);
  localparam logic [PW-1:0] PER_MAX = PW'(AUTO_PERIOD - 1);

  logic          w_boton_limpio;
  logic          r_boton_limpio_d;
  logic          w_press;
  logic          r_modo_s1;
  logic          r_modo_s2;
  logic [0:0]    r_estado;
  logic [PW-1:0] r_periodo;
  logic [PW-1:0] w_periodo_next;
  logic          w_toggle;
  logic          r_seleccion;
  logic          r_cambio;

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_antirrebote (
    .clk     (clk),
    .rst     (rst),
    .entrada (bus.boton),
    .salida  (w_boton_limpio)
  );

  assign w_press = w_boton_limpio & ~r_boton_limpio_d;

  // A press and a period expiry in the same cycle share one toggle and one counter clear.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_toggle       = 1'b0;
    w_periodo_next = r_periodo;
    if (r_estado == AUTO) begin
      if (bus.habilitar) begin
        if (w_press || (r_periodo == PER_MAX)) begin
          w_toggle       = 1'b1;
          w_periodo_next = '0;
        end else begin
          w_periodo_next = r_periodo + PW'(1);
        end
      end
    end else begin
      w_toggle       = bus.habilitar & w_press;
      w_periodo_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_modo_s1        <= 1'b0;
      r_modo_s2        <= 1'b0;
      r_estado         <= MANUAL;
      r_boton_limpio_d <= 1'b0;
      r_periodo        <= '0;
      r_seleccion      <= 1'b0;
      r_cambio         <= 1'b0;
    end else begin
      r_modo_s1        <= bus.modo_auto;
      r_modo_s2        <= r_modo_s1;
      r_estado         <= r_modo_s2 ? AUTO : MANUAL;
      r_boton_limpio_d <= w_boton_limpio;
      r_periodo        <= w_periodo_next;
      r_seleccion      <= r_seleccion ^ w_toggle;
      r_cambio         <= w_toggle;
    end
  end

  assign bus.seleccion    = r_seleccion;
  assign bus.cambio       = r_cambio;
  assign bus.boton_limpio = w_boton_limpio;

endmodule

// File: tb/tb_generador_seleccion.sv
// Self-checking bench for generador_seleccion: directed scenarios with fixed
// expected edges plus randomized traffic against a behavioural model.
module tb_generador_seleccion;

  localparam int DEB = 4;
  localparam int PER = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  generador_seleccion_if bus ();

  generador_seleccion #(
    .DEBOUNCE_CYCLES (DEB),
    .AUTO_PERIOD     (PER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Behavioural reference: inputs reach the logic two edges late; a level is
  // accepted after DEB consecutive differing cycles; auto toggles after PER enabled cycles.
  typedef struct packed {
    bit s1, s2, m1, m2, auto_on, clean, clean_d, sel, cambio;
    int run;
    int elapsed;
  } model_t;

  model_t m = '0;

  function automatic void model_edge();
    model_t n;
    bit pressed;
    bit flip;
    n = m;
    if (rst) begin
      m = '0;
      return;
    end
    pressed = m.clean && !m.clean_d;
    if (m.auto_on) flip = bus.habilitar && (pressed || m.elapsed == PER - 1);
    else           flip = bus.habilitar && pressed;
    if (!m.auto_on)         n.elapsed = 0;
    else if (bus.habilitar) n.elapsed = flip ? 0 : m.elapsed + 1;
    if (m.s2 != m.clean) begin
      n.run = m.run + 1;
      if (n.run == DEB) begin
        n.clean = m.s2;
        n.run   = 0;
      end
    end else begin
      n.run = 0;
    end
    n.clean_d = m.clean;
    n.auto_on = m.m2;
    n.s2      = m.s1;
    n.s1      = bus.boton;
    n.m2      = m.m1;
    n.m1      = bus.modo_auto;
    n.sel     = m.sel ^ flip;
    n.cambio  = flip;
    m = n;
  endfunction

  // One rising edge; inputs change only between edges, outputs are read at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_toggle(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.cambio !== 1'b1 && n < budget);
    if (bus.cambio !== 1'b1) n = budget + 1;
  endtask

  task automatic test_reset();
    bus.boton = 1'b1; bus.modo_auto = 1'b1; bus.habilitar = 1'b1; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if ({bus.seleccion, bus.cambio, bus.boton_limpio} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_during: got %b expected 000",
                 {bus.seleccion, bus.cambio, bus.boton_limpio});
      end
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if ({bus.seleccion, bus.cambio, bus.boton_limpio} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_after: got %b expected 000",
               {bus.seleccion, bus.cambio, bus.boton_limpio});
    end
    rst = 1'b1; bus.boton = 1'b0; bus.modo_auto = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_manual_press();
    int toggles = 0;
    bus.habilitar = 1'b1;
    bus.boton = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.cambio === 1'b1) toggles++;
      if (t == 5) begin
        n_chk++;
        if (bus.boton_limpio !== 1'b0) begin
          n_err++;
          $display("FAIL press_limpio_early: got %b expected 0", bus.boton_limpio);
        end
      end
      if (t == 6) begin
        n_chk++;
        if ({bus.boton_limpio, bus.seleccion, bus.cambio} !== 3'b100) begin
          n_err++;
          $display("FAIL press_edge6: got %b expected 100",
                   {bus.boton_limpio, bus.seleccion, bus.cambio});
        end
      end
      if (t == 7) begin
        n_chk++;
        if ({bus.seleccion, bus.cambio} !== 2'b11) begin
          n_err++;
          $display("FAIL press_edge7: got %b expected 11", {bus.seleccion, bus.cambio});
        end
      end
      if (t == 8) begin
        n_chk++;
        if (bus.cambio !== 1'b0) begin
          n_err++;
          $display("FAIL press_cambio_width: got %b expected 0", bus.cambio);
        end
      end
    end
    bus.boton = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (bus.cambio === 1'b1) toggles++;
    end
    n_chk++;
    if (toggles != 1 || bus.seleccion !== 1'b1 || bus.boton_limpio !== 1'b0) begin
      n_err++;
      $display("FAIL press_release: got toggles=%0d sel=%b limpio=%b expected 1/1/0",
               toggles, bus.seleccion, bus.boton_limpio);
    end
  endtask

  task automatic test_bounce();
    logic sel0 = bus.seleccion;
    int   bad  = 0;
    for (int i = 0; i < 16; i++) begin
      bus.boton = (((i >> 1) & 1) == 0);
      tick();
      if (bus.boton_limpio !== 1'b0 || bus.cambio !== 1'b0) bad++;
    end
    bus.boton = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.boton_limpio !== 1'b0 || bus.cambio !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0 || bus.seleccion !== sel0) begin
      n_err++;
      $display("FAIL bounce: got bad_cycles=%0d sel=%b expected 0/%b", bad, bus.seleccion, sel0);
    end
  endtask

  task automatic test_auto();
    int   edges[$];
    int   exp_edges[4] = '{11, 19, 27, 35};
    int   consec = 0;
    int   quiet  = 0;
    int   n;
    logic prev_c = 1'b0;
    logic sel0   = bus.seleccion;
    bus.habilitar = 1'b1;
    bus.modo_auto = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (bus.cambio === 1'b1) edges.push_back(t);
      if (bus.cambio === 1'b1 && prev_c === 1'b1) consec++;
      prev_c = bus.cambio;
    end
    n_chk++;
    if (edges.size() != 4 || consec != 0) begin
      n_err++;
      $display("FAIL auto_pulses: got %0d pulses (%0d doubled) expected 4", edges.size(), consec);
    end
    for (int i = 0; i < 4 && i < edges.size(); i++) begin
      n_chk++;
      if (edges[i] != exp_edges[i]) begin
        n_err++;
        $display("FAIL auto_edge%0d: got %0d expected %0d", i, edges[i], exp_edges[i]);
      end
    end
    n_chk++;
    if (bus.seleccion !== sel0) begin
      n_err++;
      $display("FAIL auto_parity: got %b expected %b", bus.seleccion, sel0);
    end
    bus.habilitar = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (bus.cambio === 1'b1 || bus.seleccion !== sel0) quiet++;
    end
    n_chk++;
    if (quiet != 0) begin
      n_err++;
      $display("FAIL auto_frozen: got %0d active cycles expected 0", quiet);
    end
    bus.habilitar = 1'b1;
    wait_toggle(20, n);
    n_chk++;
    if (n != 3) begin
      n_err++;
      $display("FAIL auto_resume: got %0d cycles expected 3", n);
    end
  endtask

  // Entered right after an automatic toggle, so the period counter is 0.
  task automatic test_press_auto();
    int   edges[$];
    logic sel0;
    tick();
    sel0 = bus.seleccion;
    bus.boton = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (bus.cambio === 1'b1) edges.push_back(k);
      if (k == 7) begin
        n_chk++;
        if (bus.seleccion !== ~sel0) begin
          n_err++;
          $display("FAIL press_auto_sel: got %b expected %b", bus.seleccion, ~sel0);
        end
      end
      if (k == 10) bus.boton = 1'b0;
    end
    n_chk++;
    if (edges.size() != 2 || edges[0] != 7 || edges[1] != 15) begin
      n_err++;
      $display("FAIL press_auto_edges: got %0d toggles first=%0d second=%0d expected 2 at 7,15",
               edges.size(), (edges.size() > 0) ? edges[0] : -1,
               (edges.size() > 1) ? edges[1] : -1);
    end
  endtask

  task automatic test_disabled_press();
    logic sel0;
    int   active = 0;
    bus.modo_auto = 1'b0;
    bus.habilitar = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    sel0 = bus.seleccion;
    bus.habilitar = 1'b0;
    bus.boton = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (bus.cambio === 1'b1) active++;
      if (t == 6) begin
        n_chk++;
        if (bus.boton_limpio !== 1'b1) begin
          n_err++;
          $display("FAIL disabled_limpio: got %b expected 1", bus.boton_limpio);
        end
      end
    end
    bus.boton = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (bus.cambio === 1'b1) active++;
    end
    bus.habilitar = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (bus.cambio === 1'b1) active++;
    end
    n_chk++;
    if (active != 0 || bus.seleccion !== sel0) begin
      n_err++;
      $display("FAIL disabled_press: got pulses=%0d sel=%b expected 0/%b",
               active, bus.seleccion, sel0);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int t = 0; t < 3000; t++) begin
      if (hold == 0) begin
        bus.boton = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 63) == 0) bus.modo_auto = ~bus.modo_auto;
      bus.habilitar = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      n_chk++;
      if (bus.seleccion !== m.sel) begin
        n_err++;
        $display("FAIL rand_seleccion t=%0d: got %b expected %b", t, bus.seleccion, m.sel);
      end
      n_chk++;
      if (bus.cambio !== m.cambio) begin
        n_err++;
        $display("FAIL rand_cambio t=%0d: got %b expected %b", t, bus.cambio, m.cambio);
      end
      n_chk++;
      if (bus.boton_limpio !== m.clean) begin
        n_err++;
        $display("FAIL rand_limpio t=%0d: got %b expected %b", t, bus.boton_limpio, m.clean);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.boton = 1'b0;
    bus.modo_auto = 1'b0;
    bus.habilitar = 1'b0;
    test_reset();
    test_manual_press();
    test_bounce();
    test_auto();
    test_press_auto();
    test_disabled_press();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
